sa_feed_seq: RTL
================

# sa_feed_seq

Parametrised operand sequencer for an output-stationary N×N systolic matrix multiplier. On `start` it fetches N column-vectors of A and N row-vectors of B from operand memory, skews each lane into a diagonal wavefront, drives the array's edge inputs, and gates/clears the PE accumulators. It reports `done` when the last MAC has landed. It sits between the operand RAMs and the PE array and is the generalised successor of the fixed 8×8 controller, with size, widths, accumulate mode and abort added.

## Interface
- `N`, 8, array dimension (rows = cols); legal 2..16
- `DW`, 8, operand element width
- `AW`, 10, memory word-address width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: request a multiply; sampled only in IDLE
- `abort` in 1: synchronous cancel; returns to IDLE without `done`
- `accumulate` in 1: sampled with `start`; 1 = keep the PE sums (no clear)
- `base_a`, `base_b` in AW: word address of A column 0 / B row 0; sampled with `start`
- `rd_en` out 1: read strobe to both RAMs
- `rd_addr_a`, `rd_addr_b` out AW: read addresses
- `rd_data_a`, `rd_data_b` in N*DW: read data with 1-cycle latency; lane i = bits [i*DW +: DW]
- `a_feed` out N*DW: row-edge inputs; lane i feeds PE row i
- `b_feed` out N*DW: column-edge inputs; lane j feeds PE column j
- `pe_en` out 1: PE MAC/shift enable
- `pe_clr` out 1: PE accumulator clear
- `busy` out 1: a run is in progress
- `done` out 1: one-cycle completion pulse

## Operation
- States are IDLE, CLR, RUN and DONE.
- IDLE → CLR when `start`=1. The following are latched in the same transition: `accumulate`, `base_a` and `base_b`.
- CLR lasts one cycle. It asserts `pe_clr` only when the latched `accumulate` is 0, then goes to RUN with `cnt`=0.
- RUN: `cnt` counts 0..3N-2, then the block goes to DONE.
  - `rd_en`=1 while `cnt`<N.
  - `rd_addr_a` = `base_a`+`cnt` and `rd_addr_b` = `base_b`+`cnt`. Both are truncated to AW bits (modulo 2^AW wrap).
  - Returned data is valid for 1≤`cnt`≤N. Outside that window the skew lines are loaded with 0, so PEs multiply by zero.
  - Lane i of A and lane i of B each pass through i registers. Lane 0 is combinational from the registered data stage.
  - `pe_en`=1 for `cnt`≥1, which is 3N-2 cycles. That covers the last product at PE(N-1,N-1).
- DONE lasts one cycle with `done`=1 and `busy`=0, then returns to IDLE. `start` is ignored in DONE.
- `start` while `busy` is ignored.
- `abort` has priority over every transition:
  - next state is IDLE and `cnt` goes to 0;
  - all skew registers are zeroed;
  - `pe_en`, `rd_en` and `done` are deasserted from the next cycle.
- Reset value of every output and register is 0: all feeds, strobes, addresses, `busy`, `done`, state = IDLE.
- Asynchronous reset mid-run: immediate return to reset values. No `done` is produced.

## Timing
- Let `start` be sampled at edge T0. Then:
  - CLR at T1;
  - RUN from T2 to T3N;
  - `done` at T(3N+1).
- For N=8, `done` is at T25.
- `busy`=1 in CLR and RUN, i.e. T1..T3N.
- First read at T2 with address = base. The last read is at T(N+1).
- `a_feed` lane i carries element k at T(3+k+i), for k=0..N-1. It is 0 otherwise. The same holds for `b_feed`.
- Back-to-back runs: earliest next `start` is sampled at T(3N+2), giving a period of 3N+2 cycles.

## Structure
- Package `sa_pkg` holds:
  - the state enum type `sa_state_t`;
  - a width helper `clog2`-based `CNTW` (count width for 3N-1);
  - the lane slicing function.
- Sub-module `sa_skew_line`:
  - parameters DEPTH and DW, ports `clk`, `rst_n`, `flush`, `din`, `dout`;
  - DEPTH=0 is a wire;
  - instantiated 2N times via generate.
- The top holds the FSM, the counter, the address adders and the registered data stage.

## Test plan
- **Reset:** `rst_n`=0 mid-RUN at `cnt`=5 → all outputs 0 within the same cycle; no `done` pulse after release.
- **Basic run:** N=8, `base_a`=0, `base_b`=64, A=identity, B[k][j]=k*8+j → `rd_addr_a` runs 0..7 and `rd_addr_b` 64..71 at T2..T9. `a_feed` lane 3 is 1 only at T9. `done` at T25. A PE model yields C=B.
- **Wrap:** AW=10, `base_a`=1020 → `rd_addr_a` reads 1020,1021,1022,1023,0,1,2,3.
- **Accumulate:**
  - Run 1: A=B=identity.
  - Run 2: same operands with `accumulate`=1.
  - Required: `pe_clr` never asserted in run 2; PE model C=2·I.
- **Abort:** `abort` at `cnt`=10 → state IDLE next cycle; feeds all 0; no `done`. A `start` two cycles later produces a normal run with `done` 3N+1 cycles later.
- **Parametric:** N=4, DW=16, AW=6; `start` held high continuously → `done` pulses every 14 cycles. Each run's first read occurs 2 cycles after its `start` sample.

Source files
------------

// File: rtl/sa_feed_seq_pkg.sv
// Shared types and helpers for the systolic-array operand sequencer.
package sa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } sa_state_t;

  // Counter width able to hold 0..3n-2
  function automatic int unsigned cntw(input int unsigned n);
    return $clog2(3 * n - 1);
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/sa_feed_seq_skew_line.sv
// Fixed-depth delay line for one operand lane; DEPTH=0 degenerates to a wire.
module sa_skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, flush};
      assign dout       = din;
    end else begin : g_reg
      logic [DEPTH*DW-1:0] sr_q;
      logic [DEPTH*DW-1:0] sr_d;

      always_comb begin
        sr_d = flush ? '0 : (DEPTH*DW)'({sr_q, din});
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
      end

      assign dout = sr_q[DEPTH*DW-1 -: DW];
    end
  endgenerate

endmodule

// File: rtl/sa_feed_seq.sv
// Operand sequencer for an output-stationary NxN systolic array: fetch, skew, PE gating.
module sa_feed_seq
  import sa_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          accumulate,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [N*DW-1:0] rd_data_a,
  input  logic [N*DW-1:0] rd_data_b,
  output logic [N*DW-1:0] a_feed,
  output logic [N*DW-1:0] b_feed,
  output logic          pe_en,
  output logic          pe_clr,
  output logic          busy,
  output logic          done
);

  localparam int unsigned     CNTW     = cntw(N);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(3 * N - 2);
  localparam logic [CNTW-1:0] CNT_N    = CNTW'(N);

  sa_state_t       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic [AW-1:0]   base_a_q, base_a_d;
  logic [AW-1:0]   base_b_q, base_b_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   addr_a_q, addr_a_d;
  logic [AW-1:0]   addr_b_q, addr_b_d;
  logic            pe_en_q, pe_en_d;
  logic            pe_clr_q, pe_clr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            vld_q, vld_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CLR;
          acc_d    = accumulate;
          base_a_d = base_a;
          base_b_d = base_b;
        end
      end
      S_CLR: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it
    rd_en_d  = (state_d == S_RUN) && (cnt_d < CNT_N);
    addr_a_d = rd_en_d ? base_a_d + AW'(cnt_d) : '0;
    addr_b_d = rd_en_d ? base_b_d + AW'(cnt_d) : '0;
    pe_en_d  = (state_d == S_RUN) && (cnt_d != '0);
    pe_clr_d = (state_d == S_CLR) && !acc_d;
    busy_d   = (state_d == S_CLR) || (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    // RAM data lands one cycle after the strobe; an abort discards it
    vld_d    = rd_en_q && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      base_a_q <= '0;
      base_b_q <= '0;
      rd_en_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      pe_en_q  <= 1'b0;
      pe_clr_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      rd_en_q  <= rd_en_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      pe_en_q  <= pe_en_d;
      pe_clr_q <= pe_clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vld_q    <= vld_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr_a = addr_a_q;
  assign rd_addr_b = addr_b_q;
  assign pe_en     = pe_en_q;
  assign pe_clr    = pe_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    assign a_in = vld_q ? rd_data_a[lane_lo(i, DW) +: DW] : '0;
    assign b_in = vld_q ? rd_data_b[lane_lo(i, DW) +: DW] : '0;

    sa_skew_line #(.DEPTH(i), .DW(DW)) u_skew_a (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .din   (a_in),
      .dout  (a_feed[i*DW +: DW])
    );

    sa_skew_line #(.DEPTH(i), .DW(DW)) u_skew_b (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .din   (b_in),
      .dout  (b_feed[i*DW +: DW])
    );
  end

endmodule
